// File: rtl/rgb_pwm_seq.sv
// RGB LED PWM sequencer: fades each colour up and down in turn, with a manual-duty override.
// Duties change only at PWM period boundaries; dropping enable blanks the outputs immediately.
module rgb_pwm_seq #(
   parameter int unsigned PRESCALE     = 48,
   parameter int unsigned STEP_PERIODS = 4
) (
   input  logic        hw_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        man_mode,
   input  logic        man_load,
   input  logic [23:0] man_duty,
   output logic        pwm_red,
   output logic        pwm_green,
   output logic        pwm_blue,
   output logic [1:0]  color_idx,
   output logic        period_start
);

   // state     | meaning
   // IDLE      | brightness held at 0, waiting for a boundary with enable high
   // FADE_UP   | brightness +1 every STEP_PERIODS boundaries until 255
   // FADE_DOWN | brightness -1 every STEP_PERIODS boundaries until 0
   // ADVANCE   | one cycle: select the next colour, then FADE_UP
   typedef enum logic [1:0] {IDLE, FADE_UP, FADE_DOWN, ADVANCE} state_t;

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
   localparam logic [7:0]  STEP_MAX  = 8'(STEP_PERIODS - 1);

   state_t      state;
   logic [15:0] presc_cnt;
   logic [7:0]  pwm_cnt;
   logic [7:0]  brightness;
   logic [7:0]  step_cnt;
   logic [23:0] man_duty_q;
   logic [23:0] duty_q;
   logic [23:0] auto_duty;
   logic [23:0] man_next;
   logic        tick;
   logic        boundary;
   logic        step_done;

   assign tick      = (presc_cnt == PRESC_MAX);
   assign boundary  = tick && (pwm_cnt == 8'hFF);
   assign step_done = (step_cnt == STEP_MAX);
   // A load coinciding with a boundary must feed that boundary directly.
   assign man_next  = man_load ? man_duty : man_duty_q;

   always_comb begin
      auto_duty = '0;
      case (color_idx)
         2'd0:    auto_duty[23:16] = brightness;
         2'd1:    auto_duty[15:8]  = brightness;
         default: auto_duty[7:0]   = brightness;
      endcase
   end

   always_ff @(posedge hw_clk) begin
      if (reset) begin
         presc_cnt    <= '0;
         pwm_cnt      <= '0;
         state        <= IDLE;
         brightness   <= '0;
         step_cnt     <= '0;
         color_idx    <= 2'd0;
         man_duty_q   <= '0;
         duty_q       <= '0;
         pwm_red      <= 1'b0;
         pwm_green    <= 1'b0;
         pwm_blue     <= 1'b0;
         period_start <= 1'b0;
      end else begin
         presc_cnt    <= tick ? 16'd0 : presc_cnt + 16'd1;
         if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
         period_start <= boundary;
         if (man_load)
            man_duty_q <= man_duty;
         pwm_red   <= (pwm_cnt < duty_q[23:16]);
         pwm_green <= (pwm_cnt < duty_q[15:8]);
         pwm_blue  <= (pwm_cnt < duty_q[7:0]);

         if (!enable) begin
            // Clearing the duties here blanks the outputs one cycle later.
            state      <= IDLE;
            brightness <= '0;
            step_cnt   <= '0;
            duty_q     <= '0;
         end else begin
            if (boundary)
               duty_q <= man_mode ? man_next : auto_duty;
            if (!man_mode) begin
               case (state)
                  IDLE: begin
                     if (boundary) begin
                        state    <= FADE_UP;
                        step_cnt <= '0;
                     end
                  end
                  FADE_UP: begin
                     if (boundary) begin
                        if (step_done) begin
                           step_cnt <= '0;
                           if (brightness != 8'hFF)
                              brightness <= brightness + 8'd1;
                           if (brightness >= 8'hFE)
                              state <= FADE_DOWN;
                        end else begin
                           step_cnt <= step_cnt + 8'd1;
                        end
                     end
                  end
                  FADE_DOWN: begin
                     if (boundary) begin
                        if (step_done) begin
                           step_cnt <= '0;
                           if (brightness != 8'h00)
                              brightness <= brightness - 8'd1;
                           if (brightness <= 8'h01)
                              state <= ADVANCE;
                        end else begin
                           step_cnt <= step_cnt + 8'd1;
                        end
                     end
                  end
                  ADVANCE: begin
                     color_idx <= (color_idx == 2'd2) ? 2'd0 : color_idx + 2'd1;
                     state     <= FADE_UP;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_pwm_seq.sv
// Directed bench for rgb_pwm_seq: manual duties, boundary loads, enable drop, full auto run, reset.
// A negedge monitor records per-period high counts indexed by period_start pulse number.
module tb_rgb_pwm_seq;

   logic        hw_clk = 1'b0;
   logic        reset, enable, man_mode, man_load;
   logic [23:0] man_duty;
   logic        pwm_red, pwm_green, pwm_blue, period_start;
   logic [1:0]  color_idx;
   logic        pwm_red2, pwm_green2, pwm_blue2, period_start2;
   logic [1:0]  color_idx2;

   int vectors = 0;
   int miscompares = 0;

   rgb_pwm_seq #(.PRESCALE(1), .STEP_PERIODS(1)) dut (
      .hw_clk(hw_clk), .reset(reset), .enable(enable), .man_mode(man_mode),
      .man_load(man_load), .man_duty(man_duty), .pwm_red(pwm_red),
      .pwm_green(pwm_green), .pwm_blue(pwm_blue), .color_idx(color_idx),
      .period_start(period_start));

   rgb_pwm_seq #(.PRESCALE(3), .STEP_PERIODS(2)) dut2 (
      .hw_clk(hw_clk), .reset(reset), .enable(enable), .man_mode(man_mode),
      .man_load(man_load), .man_duty(man_duty), .pwm_red(pwm_red2),
      .pwm_green(pwm_green2), .pwm_blue(pwm_blue2), .color_idx(color_idx2),
      .period_start(period_start2));

   always #5 hw_clk = ~hw_clk;

   // hist[k] holds the high counts of the period that follows pulse k.
   int         pulse_cnt = 0, cyc = 0, first_ps = -1, first_ps2 = -1;
   int         acc_r = 0, acc_g = 0, acc_b = 0, onehot_err = 0;
   bit         onehot_chk = 1'b0;
   int         red_hist[4096], grn_hist[4096], blu_hist[4096];
   logic [1:0] last_color = 2'd0;
   logic [1:0] color_log[$];

   always @(negedge hw_clk) begin
      if (reset) begin
         pulse_cnt = 0; cyc = 0; first_ps = -1; first_ps2 = -1;
         acc_r = 0; acc_g = 0; acc_b = 0;
         last_color = color_idx;
         color_log.delete();
      end else begin
         cyc++;
         acc_r += int'(pwm_red);
         acc_g += int'(pwm_green);
         acc_b += int'(pwm_blue);
         if (onehot_chk && (int'(pwm_red) + int'(pwm_green) + int'(pwm_blue) > 1))
            onehot_err++;
         if (color_idx != last_color) begin
            color_log.push_back(color_idx);
            last_color = color_idx;
         end
         if (period_start2 && first_ps2 < 0)
            first_ps2 = cyc;
         if (period_start) begin
            if (first_ps < 0) first_ps = cyc;
            if (pulse_cnt < 4096) begin
               red_hist[pulse_cnt] = acc_r;
               grn_hist[pulse_cnt] = acc_g;
               blu_hist[pulse_cnt] = acc_b;
            end
            acc_r = 0; acc_g = 0; acc_b = 0;
            pulse_cnt++;
         end
      end
   end

   task automatic nstep();
      @(negedge hw_clk);
      #1;
   endtask

   task automatic wait_pulses(input int n, input int lim);
      int g = 0;
      while (pulse_cnt < n && g < lim) begin
         nstep();
         g++;
      end
      vectors++;
      if (pulse_cnt < n) begin
         miscompares++;
         $display("FAIL wait_pulses: got %0d pulses, required %0d", pulse_cnt, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; man_mode = 1'b0; man_load = 1'b0; man_duty = '0;
      repeat (4) nstep();
      vectors++;
      if ({pwm_red, pwm_green, pwm_blue, period_start} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b required 0000", {pwm_red, pwm_green, pwm_blue, period_start});
      end
      vectors++;
      if (color_idx !== 2'd0 || color_idx2 !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_color: got %0d/%0d required 0", color_idx, color_idx2);
      end
   endtask

   task automatic test_manual();
      man_mode = 1'b1; enable = 1'b1; reset = 1'b0;
      nstep();
      man_duty = 24'h80_00FF; man_load = 1'b1;
      nstep();
      man_load = 1'b0;
      wait_pulses(3, 2000);
      vectors++;
      if (first_ps !== 256 || cyc !== 768) begin
         miscompares++;
         $display("FAIL first_period: got first=%0d third=%0d required 256/768", first_ps, cyc);
      end
      vectors++;
      if (first_ps2 !== 768) begin
         miscompares++;
         $display("FAIL prescale3_first_period: got %0d required 768", first_ps2);
      end
      vectors++;
      if (red_hist[2] !== 128 || grn_hist[2] !== 0 || blu_hist[2] !== 255) begin
         miscompares++;
         $display("FAIL manual_duty: got r=%0d g=%0d b=%0d required 128/0/255",
                  red_hist[2], grn_hist[2], blu_hist[2]);
      end
   endtask

   task automatic test_load_at_boundary();
      repeat (255) nstep();
      man_duty = 24'h10_2030; man_load = 1'b1;
      nstep();
      man_load = 1'b0; man_duty = 24'hFF_FFFF;
      vectors++;
      if (period_start !== 1'b1) begin
         miscompares++;
         $display("FAIL load_alignment: got period_start=%b required 1", period_start);
      end
      wait_pulses(6, 2000);
      vectors++;
      if (red_hist[3] !== 128 || grn_hist[3] !== 0 || blu_hist[3] !== 255) begin
         miscompares++;
         $display("FAIL pre_load_period: got r=%0d g=%0d b=%0d required 128/0/255",
                  red_hist[3], grn_hist[3], blu_hist[3]);
      end
      for (int k = 4; k <= 5; k++) begin
         vectors++;
         if (red_hist[k] !== 16 || grn_hist[k] !== 32 || blu_hist[k] !== 48) begin
            miscompares++;
            $display("FAIL boundary_load[%0d]: got r=%0d g=%0d b=%0d required 16/32/48",
                     k, red_hist[k], grn_hist[k], blu_hist[k]);
         end
      end
   endtask

   task automatic test_enable_low_manual();
      int highs = 0;
      repeat (10) nstep();
      vectors++;
      if (pwm_red !== 1'b1) begin
         miscompares++;
         $display("FAIL manual_red_before_drop: got %b required 1", pwm_red);
      end
      enable = 1'b0;
      nstep(); nstep();
      vectors++;
      if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) begin
         miscompares++;
         $display("FAIL manual_drop_2cyc: got %b required 000", {pwm_red, pwm_green, pwm_blue});
      end
      for (int i = 0; i < 600; i++) begin
         nstep();
         highs += int'(pwm_red) + int'(pwm_green) + int'(pwm_blue);
      end
      vectors++;
      if (highs !== 0) begin
         miscompares++;
         $display("FAIL manual_while_disabled: got %0d high samples required 0", highs);
      end
   endtask

   task automatic test_fade();
      int idx_t[5] = '{2, 3, 256, 257, 258};
      int red_t[5] = '{0, 1, 254, 255, 254};
      int g = 0;
      reset = 1'b1; man_mode = 1'b0; enable = 1'b1;
      repeat (3) nstep();
      onehot_chk = 1'b1;
      reset = 1'b0;
      wait_pulses(259, 80000);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (red_hist[idx_t[i]] !== red_t[i] || grn_hist[idx_t[i]] !== 0 || blu_hist[idx_t[i]] !== 0) begin
            miscompares++;
            $display("FAIL fade[%0d]: got r=%0d g=%0d b=%0d required %0d/0/0", idx_t[i],
                     red_hist[idx_t[i]], grn_hist[idx_t[i]], blu_hist[idx_t[i]], red_t[i]);
         end
      end
      wait_pulses(510, 80000);
      nstep();
      while (period_start !== 1'b1 && g < 300) begin
         nstep();
         g++;
      end
      vectors++;
      if (pulse_cnt !== 511 || color_idx !== 2'd0) begin
         miscompares++;
         $display("FAIL advance_pending: got pulse=%0d color=%0d required 511/0", pulse_cnt, color_idx);
      end
      nstep();
      vectors++;
      if (color_idx !== 2'd1) begin
         miscompares++;
         $display("FAIL advance_single_cycle: got color=%0d required 1", color_idx);
      end
      wait_pulses(513, 1000);
      vectors++;
      if (red_hist[511] !== 1 || red_hist[512] !== 0 || grn_hist[512] !== 0) begin
         miscompares++;
         $display("FAIL fade_bottom: got r511=%0d r512=%0d g512=%0d required 1/0/0",
                  red_hist[511], red_hist[512], grn_hist[512]);
      end
   endtask

   task automatic test_enable_drop();
      int highs = 0;
      int c;
      wait_pulses(611, 30000);
      vectors++;
      if (grn_hist[610] !== 98 || red_hist[610] !== 0) begin
         miscompares++;
         $display("FAIL green_fade: got g=%0d r=%0d required 98/0", grn_hist[610], red_hist[610]);
      end
      repeat (20) nstep();
      vectors++;
      if (pwm_green !== 1'b1) begin
         miscompares++;
         $display("FAIL green_before_drop: got %b required 1", pwm_green);
      end
      enable = 1'b0;
      nstep(); nstep();
      vectors++;
      if ({pwm_red, pwm_green, pwm_blue} !== 3'b000 || color_idx !== 2'd1) begin
         miscompares++;
         $display("FAIL auto_drop: got pwm=%b color=%0d required 000/1",
                  {pwm_red, pwm_green, pwm_blue}, color_idx);
      end
      for (int i = 0; i < 300; i++) begin
         nstep();
         highs += int'(pwm_red) + int'(pwm_green) + int'(pwm_blue);
      end
      vectors++;
      if (highs !== 0) begin
         miscompares++;
         $display("FAIL auto_disabled: got %0d high samples required 0", highs);
      end
      enable = 1'b1;
      c = pulse_cnt;
      wait_pulses(c + 4, 2000);
      vectors++;
      if (grn_hist[c + 2] !== 0 || grn_hist[c + 3] !== 1 || color_idx !== 2'd1) begin
         miscompares++;
         $display("FAIL fade_restart: got g=%0d,%0d color=%0d required 0,1 color 1",
                  grn_hist[c + 2], grn_hist[c + 3], color_idx);
      end
   endtask

   task automatic test_full_run();
      int g = 0;
      while (color_idx !== 2'd2 && g < 200000) begin nstep(); g++; end
      g = 0;
      while (color_idx !== 2'd0 && g < 200000) begin nstep(); g++; end
      vectors++;
      if (color_log.size() !== 3) begin
         miscompares++;
         $display("FAIL color_changes: got %0d changes required 3", color_log.size());
      end else if (color_log[0] !== 2'd1 || color_log[1] !== 2'd2 || color_log[2] !== 2'd0) begin
         miscompares++;
         $display("FAIL color_sequence: got %0d,%0d,%0d required 1,2,0",
                  color_log[0], color_log[1], color_log[2]);
      end
      vectors++;
      if (onehot_err !== 0) begin
         miscompares++;
         $display("FAIL one_hot: got %0d overlapping samples required 0", onehot_err);
      end
   endtask

   task automatic test_reset_mid_fade();
      int c = pulse_cnt;
      int g = 0;
      wait_pulses(c + 300, 80000);
      repeat (20) nstep();
      vectors++;
      if (pwm_red !== 1'b1) begin
         miscompares++;
         $display("FAIL red_in_fade_down: got %b required 1", pwm_red);
      end
      reset = 1'b1;
      onehot_chk = 1'b0;
      nstep();
      vectors++;
      if ({pwm_red, pwm_green, pwm_blue, period_start} !== 4'b0000 || color_idx !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_mid_fade: got pwm/ps=%b color=%0d required 0000/0",
                  {pwm_red, pwm_green, pwm_blue, period_start}, color_idx);
      end
      repeat (3) nstep();
      reset = 1'b0;
      wait_pulses(1, 1000);
      vectors++;
      if (first_ps !== 256) begin
         miscompares++;
         $display("FAIL post_reset_period: got %0d required 256", first_ps);
      end
      while (first_ps2 < 0 && g < 1000) begin nstep(); g++; end
      vectors++;
      if (first_ps2 !== 768) begin
         miscompares++;
         $display("FAIL post_reset_prescale3: got %0d required 768", first_ps2);
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_load_at_boundary();
      test_enable_low_manual();
      test_fade();
      test_enable_drop();
      test_full_run();
      test_reset_mid_fade();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
